// File: rtl/ant_pheromone_table.sv
// ant_pheromone_table
//   Pheromone table for ant-colony adaptive routing. There is one instance per router.
//   Each entry is a saturating pheromone count for one (destination node, neighbour port) pair.
//   Neighbour ports are 1..N_PORTS-1. Port 0 is the local port and has no entries.
//
//   Lookup : argmax over the neighbour ports of the requested row, with the arrival port
//            excluded. Ties resolve to the lowest index. The result is registered, so it
//            appears one cycle after the request.
//   Update : backward-ant reinforcement through a ready/valid handshake.
//            The parent port gains PH_DELTA and every other neighbour loses 1.
//            Both directions saturate at PH_MAX / PH_MIN.
//
//   Optional feature macro: PH_EVAPORATION_EN
//     When defined, a free-running counter starts a sweep every EVAP_PERIOD cycles.
//     The sweep decrements one row per cycle, and o_update_ready is low while it runs.
//
// Ports
//   i_clk, i_reset                       clock, asynchronous active-high reset
//   i_lookup_valid/_dest/_parent         lookup request (always accepted)
//   o_result_valid/_port/_onehot         registered lookup result
//   i_update_valid/_dest/_parent         update request
//   o_update_ready                       update handshake ready
module ant_pheromone_table #(
    parameter int NODES       = 16,
    parameter int N_PORTS     = 5,
    parameter int PH_WIDTH    = 8,
    parameter int PH_MAX      = 255,
    parameter int PH_MIN      = 0,
    parameter int PH_INIT     = 0,
    parameter int PH_DELTA    = 4,
    parameter int EVAP_PERIOD = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_lookup_valid,
    input  logic [$clog2(NODES)-1:0]   i_lookup_dest,
    input  logic [$clog2(N_PORTS)-1:0] i_lookup_parent,
    output logic                       o_result_valid,
    output logic [$clog2(N_PORTS)-1:0] o_result_port,
    output logic [N_PORTS-1:0]         o_result_onehot,
    input  logic                       i_update_valid,
    output logic                       o_update_ready,
    input  logic [$clog2(NODES)-1:0]   i_update_dest,
    input  logic [$clog2(N_PORTS)-1:0] i_update_parent
);

    localparam int DEST_W = $clog2(NODES);
    localparam int PORT_W = $clog2(N_PORTS);
    localparam int NB     = N_PORTS - 1;   // neighbour columns; column j holds port j+1

    // Saturating reinforcement. The sum is one bit wider so it cannot wrap before the clamp.
    function automatic logic [PH_WIDTH-1:0] sat_inc(input logic [PH_WIDTH-1:0] v);
        logic [PH_WIDTH:0] sum;
        sum = {1'b0, v} + (PH_WIDTH+1)'(PH_DELTA);
        if (sum > (PH_WIDTH+1)'(PH_MAX)) return PH_WIDTH'(PH_MAX);
        return sum[PH_WIDTH-1:0];
    endfunction

    // Saturating decay by one, clamped at the floor.
    function automatic logic [PH_WIDTH-1:0] sat_dec(input logic [PH_WIDTH-1:0] v);
        if (v > PH_WIDTH'(PH_MIN)) return v - 1'b1;
        return PH_WIDTH'(PH_MIN);
    endfunction

    logic [PH_WIDTH-1:0] tbl_q [NODES][NB];
    logic [PH_WIDTH-1:0] tbl_d [NODES][NB];

    logic                result_valid_q;
    logic [PORT_W-1:0]   result_port_q;
    logic [N_PORTS-1:0]  result_onehot_q;

    logic                sweep_en;
    logic [DEST_W-1:0]   sweep_row;
    logic                update_ready;

`ifdef PH_EVAPORATION_EN
    localparam int CNT_W = (EVAP_PERIOD > 1) ? $clog2(EVAP_PERIOD) : 1;

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   evap_cnt_q;
    logic [DEST_W-1:0]  row_q;
    logic               ready_q;

    // The counter never pauses, so the sweep start points stay EVAP_PERIOD apart.
    // ready_q is registered together with the state, so it is low for exactly the SWEEP cycles.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            evap_cnt_q <= '0;
            row_q      <= '0;
            ready_q    <= 1'b1;
        end else begin
            evap_cnt_q <= (evap_cnt_q == CNT_W'(EVAP_PERIOD - 1)) ? '0 : evap_cnt_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (evap_cnt_q == CNT_W'(EVAP_PERIOD - 1)) begin
                        state_q <= S_SWEEP;
                        row_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (row_q == DEST_W'(NODES - 1)) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sweep_en     = (state_q == S_SWEEP);
    assign sweep_row    = row_q;
    assign update_ready = ready_q;
`else
    assign sweep_en     = 1'b0;
    assign sweep_row    = '0;
    assign update_ready = 1'b1;
`endif

    // Requests that name port 0, a port past the last neighbour, or a row past the last
    // node still complete the handshake, but they leave the table unchanged.
    logic upd_apply;
    logic lkp_dest_ok;
    assign upd_apply = i_update_valid && update_ready
                       && (i_update_parent != '0)
                       && (int'(i_update_parent) < N_PORTS)
                       && (int'(i_update_dest) < NODES);
    assign lkp_dest_ok = (int'(i_lookup_dest) < NODES);

    // Next table state. The sweep and the update never overlap because ready is low
    // during a sweep.
    always_comb begin
        tbl_d = tbl_q;
        if (sweep_en) begin
            for (int j = 0; j < NB; j++) begin
                tbl_d[sweep_row][j] = sat_dec(tbl_q[sweep_row][j]);
            end
        end else if (upd_apply) begin
            for (int j = 0; j < NB; j++) begin
                if (PORT_W'(j + 1) == i_update_parent)
                    tbl_d[i_update_dest][j] = sat_inc(tbl_q[i_update_dest][j]);
                else
                    tbl_d[i_update_dest][j] = sat_dec(tbl_q[i_update_dest][j]);
            end
        end
    end

    // Argmax over the current (pre-write) table contents.
    // A strict '>' keeps the earliest candidate when values tie.
    logic                found;
    logic [PH_WIDTH-1:0] best_val;
    logic [PORT_W-1:0]   best_port;
    logic [PH_WIDTH-1:0] cand;
    always_comb begin
        found     = 1'b0;
        best_val  = '0;
        best_port = '0;
        cand      = '0;
        for (int j = 0; j < NB; j++) begin
            cand = lkp_dest_ok ? tbl_q[i_lookup_dest][j] : PH_WIDTH'(PH_MIN);
            if (PORT_W'(j + 1) != i_lookup_parent) begin
                if (!found || (cand > best_val)) begin
                    found     = 1'b1;
                    best_val  = cand;
                    best_port = PORT_W'(j + 1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int r = 0; r < NODES; r++) begin
                for (int j = 0; j < NB; j++) begin
                    tbl_q[r][j] <= PH_WIDTH'(PH_INIT);
                end
            end
            result_valid_q  <= 1'b0;
            result_port_q   <= '0;
            result_onehot_q <= '0;
        end else begin
            tbl_q          <= tbl_d;
            result_valid_q <= i_lookup_valid;
            // The result outputs hold their last value between lookups.
            if (i_lookup_valid) begin
                result_port_q   <= best_port;
                result_onehot_q <= N_PORTS'(1) << best_port;
            end
        end
    end

    assign o_result_valid  = result_valid_q;
    assign o_result_port   = result_port_q;
    assign o_result_onehot = result_onehot_q;
    assign o_update_ready  = update_ready;

endmodule

// File: tb/tb_ant_pheromone_table.sv
// Bench for ant_pheromone_table (NODES=4, N_PORTS=5, PH_WIDTH=4, PH_MAX=15, PH_DELTA=1).
// The reference model keeps the table as a plain integer array.
// The expected lookup result is the argmax computed from that array.
module tb_ant_pheromone_table;

    localparam int NODES    = 4;
    localparam int N_PORTS  = 5;
    localparam int PH_WIDTH = 4;
    localparam int PH_MAX   = 15;
    localparam int PH_MIN   = 0;
    localparam int PH_INIT  = 0;
    localparam int PH_DELTA = 1;
    localparam int EVAP_P   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       lv;
    logic [1:0] ld;
    logic [2:0] lp;
    logic       rv;
    logic       uv;
    logic [1:0] ud;
    logic [2:0] up;
    logic [2:0] rport;
    logic [4:0] roh;
    logic       urdy;

    int total = 0;
    int bad   = 0;
    int model [NODES][N_PORTS];

    always #5 clk = ~clk;

    ant_pheromone_table #(
        .NODES(NODES), .N_PORTS(N_PORTS), .PH_WIDTH(PH_WIDTH), .PH_MAX(PH_MAX),
        .PH_MIN(PH_MIN), .PH_INIT(PH_INIT), .PH_DELTA(PH_DELTA), .EVAP_PERIOD(EVAP_P)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_lookup_valid(lv), .i_lookup_dest(ld), .i_lookup_parent(lp),
        .o_result_valid(rv), .o_result_port(rport), .o_result_onehot(roh),
        .i_update_valid(uv), .o_update_ready(urdy),
        .i_update_dest(ud), .i_update_parent(up)
    );

    function automatic int ref_pick(input int d, input int par);
        int best;
        int bv;
        best = -1;
        bv   = -1;
        for (int p = 1; p < N_PORTS; p++) begin
            if (p != par && model[d][p] > bv) begin
                bv   = model[d][p];
                best = p;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NODES; r++)
            for (int p = 0; p < N_PORTS; p++)
                model[r][p] = PH_INIT;
    endtask

    task automatic model_update(input int d, input int par);
        if (par >= 1 && par < N_PORTS && d < NODES) begin
            for (int p = 1; p < N_PORTS; p++) begin
                if (p == par) model[d][p] = (model[d][p] + PH_DELTA > PH_MAX) ? PH_MAX : model[d][p] + PH_DELTA;
                else          model[d][p] = (model[d][p] - 1 < PH_MIN) ? PH_MIN : model[d][p] - 1;
            end
        end
    endtask

    task automatic model_sweep();
        for (int r = 0; r < NODES; r++)
            for (int p = 1; p < N_PORTS; p++)
                model[r][p] = (model[r][p] - 1 < PH_MIN) ? PH_MIN : model[r][p] - 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lv = 1'b0; ld = '0; lp = '0;
        uv = 1'b0; ud = '0; up = '0;
    endtask

    // Drives one lookup and returns what the DUT registered for it.
    task automatic lookup(input int d, input int par,
                          output logic v, output logic [2:0] port, output logic [4:0] oh);
        lv = 1'b1; ld = 2'(d); lp = 3'(par);
        step();
        lv = 1'b0;
        v = rv; port = rport; oh = roh;
    endtask

    // Drives one update once ready is high, and mirrors it in the model.
    task automatic update(input int d, input int par);
        int waited;
        waited = 0;
        while (!urdy && waited < 100) begin
            step();
            waited++;
        end
        if (!urdy) begin
            total++; bad++;
            $display("FAIL update_ready_timeout got=%0b exp=1", urdy);
        end
        uv = 1'b1; ud = 2'(d); up = 3'(par);
        step();
        uv = 1'b0;
        model_update(d, par);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", rv); end
        total++; if (rport !== 3'd0) begin bad++; $display("FAIL reset_port got=%0d exp=0", rport); end
        total++; if (roh !== 5'b0) begin bad++; $display("FAIL reset_onehot got=%b exp=00000", roh); end
        total++; if (urdy !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", urdy); end
        rst = 1'b0;
        model_reset();
        step();
    endtask

    task automatic test_lookup_basic();
        logic v; logic [2:0] p; logic [4:0] oh;
        lookup(2, 1, v, p, oh);
        total++; if (v !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", v); end
        total++; if (p !== 3'd2) begin bad++; $display("FAIL basic_port got=%0d exp=2", p); end
        total++; if (oh !== 5'b00100) begin bad++; $display("FAIL basic_onehot got=%b exp=00100", oh); end
        step();
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%0b exp=0", rv); end
        total++; if (rport !== 3'd2) begin bad++; $display("FAIL basic_hold got=%0d exp=2", rport); end
    endtask

    task automatic test_reinforce();
        logic v; logic [2:0] p; logic [4:0] oh;
        repeat (3) update(2, 3);
        lookup(2, 1, v, p, oh);
        total++; if (p !== 3'd3) begin bad++; $display("FAIL reinforce_port got=%0d exp=3", p); end
        total++; if (model[2][3] != 3) begin bad++; $display("FAIL reinforce_model got=%0d exp=3", model[2][3]); end
        lookup(2, 3, v, p, oh);
        total++; if (p !== 3'd1) begin bad++; $display("FAIL reinforce_excl got=%0d exp=1", p); end
    endtask

    task automatic test_saturation();
        logic v; logic [2:0] p; logic [4:0] oh;
        repeat (20) update(1, 4);
        lookup(1, 1, v, p, oh);
        total++; if (p !== 3'd4) begin bad++; $display("FAIL sat_port got=%0d exp=4", p); end
        // Port 4 must sit at 15 here. After 14 decrements it should be 1, while port 2 reaches 14.
        repeat (14) update(1, 2);
        lookup(1, 2, v, p, oh);
        total++; if (p !== 3'd4) begin bad++; $display("FAIL sat_ceiling got=%0d exp=4", p); end
        // Ports 1 and 3 must not have wrapped below zero.
        lookup(1, 4, v, p, oh);
        total++; if (p !== 3'd2) begin bad++; $display("FAIL sat_floor got=%0d exp=2", p); end
    endtask

    task automatic test_parent_exclusion();
        logic v; logic [2:0] p; logic [4:0] oh;
        repeat (5) update(3, 3);
        repeat (3) update(3, 1);   // row3 = {3,0,2,0}
        lookup(3, 1, v, p, oh);
        total++; if (p !== 3'd3) begin bad++; $display("FAIL excl_p1 got=%0d exp=3", p); end
        lookup(3, 2, v, p, oh);
        total++; if (p !== 3'd1) begin bad++; $display("FAIL excl_p2 got=%0d exp=1", p); end
        update(3, 0);              // port 0 is not a neighbour: the table must not change
        update(3, 7);
        lookup(3, 0, v, p, oh);
        total++; if (p !== 3'd1 || oh !== 5'b00010) begin bad++; $display("FAIL excl_invalid got=%0d/%b exp=1/00010", p, oh); end
    endtask

    task automatic test_same_cycle();
        int exp;
        lv = 1'b1; ld = 2'd0; lp = 3'd1;
        uv = 1'b1; ud = 2'd0; up = 3'd2;
        step();
        idle_inputs();
        model_update(0, 2);
        total++; if (rport !== 3'd2) begin bad++; $display("FAIL same_rbw1 got=%0d exp=2", rport); end
        // Row0 is now {0,1,0,0}. The lookup must see port 2 even though the update moves the peak to port 4.
        lv = 1'b1; ld = 2'd0; lp = 3'd1;
        uv = 1'b1; ud = 2'd0; up = 3'd4;
        step();
        idle_inputs();
        model_update(0, 4);
        total++; if (rport !== 3'd2) begin bad++; $display("FAIL same_rbw2 got=%0d exp=2", rport); end
        exp = ref_pick(0, 1);
        lv = 1'b1; ld = 2'd0; lp = 3'd1;
        step();
        idle_inputs();
        total++; if (rport !== 3'(exp) || exp != 4) begin bad++; $display("FAIL same_after got=%0d exp=4", rport); end
    endtask

    task automatic test_back_to_back();
        int exp [8];
        for (int i = 0; i < 8; i++) begin
            lv = 1'b1; ld = 2'(i % NODES); lp = 3'(i % 3 + 1);
            exp[i] = ref_pick(i % NODES, i % 3 + 1);
            step();
            total++;
            if (rv !== 1'b1 || rport !== 3'(exp[i]) || roh !== 5'(1 << exp[i])) begin
                bad++;
                $display("FAIL b2b_%0d got=%0b/%0d/%b exp=1/%0d", i, rv, rport, roh, exp[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int exp_port;
        int exp_v;
        exp_port = ref_pick(0, 0);
        lv = 1'b1; ld = 2'd0; lp = 3'd0;
        step();
        for (int i = 0; i < 400; i++) begin
            lv = 1'($urandom_range(0, 1));
            ld = 2'($urandom_range(0, NODES - 1));
            lp = 3'($urandom_range(0, 7));
            uv = ($urandom_range(0, 3) != 0);
            ud = 2'($urandom_range(0, NODES - 1));
            up = 3'($urandom_range(0, 7));
            exp_v = lv;
            if (lv) exp_port = ref_pick(int'(ld), int'(lp));
            if (uv) model_update(int'(ud), int'(up));
            step();
            total++;
            if (rv !== 1'(exp_v) || rport !== 3'(exp_port) || (exp_v == 1 && roh !== 5'(1 << exp_port))) begin
                bad++;
                $display("FAIL rand_%0d got=%0b/%0d/%b exp=%0d/%0d", i, rv, rport, roh, exp_v, exp_port);
            end
            total++; if (urdy !== 1'b1) begin bad++; $display("FAIL rand_ready_%0d got=%0b exp=1", i, urdy); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midway();
        logic v; logic [2:0] p; logic [4:0] oh;
        lv = 1'b1; ld = 2'd1; lp = 3'd2;
        uv = 1'b1; ud = 2'd1; up = 3'd3;
        #2 rst = 1'b1;
        #1;
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL midrst_async got=%0b exp=0", rv); end
        step();
        idle_inputs();
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL midrst_pulse got=%0b exp=0", rv); end
        rst = 1'b0;
        model_reset();
        step();
        lookup(1, 1, v, p, oh);
        total++; if (p !== 3'd2 || v !== 1'b1) begin bad++; $display("FAIL midrst_table got=%0d exp=2", p); end
    endtask

`ifdef PH_EVAPORATION_EN
    task automatic test_evaporation();
        logic v; logic [2:0] p; logic [4:0] oh;
        int waited;
        int low;
        repeat (3) update(0, 4);
        waited = 0;
        while (urdy && waited < 40) begin step(); waited++; end
        low = 0;
        while (!urdy && low < 50) begin step(); low++; end
        model_sweep();
        total++; if (low != NODES) begin bad++; $display("FAIL evap_ready_low got=%0d exp=%0d", low, NODES); end
        // Row0 port4 should be 2 now. One update to port 3 makes {0,0,1,1}, a tie that resolves to port 3.
        update(0, 3);
        lookup(0, 1, v, p, oh);
        total++; if (p !== 3'(ref_pick(0, 1)) || p !== 3'd3) begin bad++; $display("FAIL evap_value got=%0d exp=3", p); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef PH_EVAPORATION_EN
        test_evaporation();
`else
        test_lookup_basic();
        test_reinforce();
        test_saturation();
        test_parent_exclusion();
        test_same_cycle();
        test_back_to_back();
        test_random();
        test_reset_midway();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
